// File: rtl/dut_handshake_responder.sv
// DUT-side handshake responder: accumulates operands and serves serial scan dumps of its state.
// Optional build macro DUFT_RESP_SAT_EN: saturating accumulate plus sticky saturation flag in dump.
module dut_handshake_responder #(
  parameter int unsigned CHAIN_LEN  = 32,
  parameter int unsigned DUMP_NBR   = 2,
  parameter int unsigned OP_LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CHAIN_LEN-1:0] data_in,
  output logic [CHAIN_LEN-1:0] data_out,
  input  logic                 dut_val_op,
  output logic                 dut_op_ack,
  output logic                 dut_op_commit,
  input  logic                 dut_commit_ack,
  input  logic                 ex_sen,
  input  logic                 dft_val_op,
  output logic                 dft_op_ack,
  output logic [CHAIN_LEN-1:0] dft_out,
  output logic                 dft_out_strobe,
  output logic                 dft_op_commit,
  input  logic                 dft_commit_ack
);

  localparam int unsigned BW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam int unsigned WW = (DUMP_NBR > 1) ? $clog2(DUMP_NBR) : 1;
  localparam int unsigned LW = (OP_LATENCY > 1) ? $clog2(OP_LATENCY) : 1;
  localparam logic [BW-1:0] LastBit  = BW'(CHAIN_LEN - 1);
  localparam logic [WW-1:0] LastWord = WW'(DUMP_NBR - 1);
  localparam logic [LW-1:0] LatInit  = LW'(OP_LATENCY - 1);

  typedef enum logic [2:0] {
    StIdle, StAck, StBusy, StCommit, StDack, StDshift, StDcommit
  } state_e;

  state_e               r_state;
  logic [CHAIN_LEN-1:0] r_operand;
  logic [CHAIN_LEN-1:0] r_acc;
  logic [CHAIN_LEN-1:0] r_count;
  logic [CHAIN_LEN-1:0] r_data_out;
  logic [LW-1:0]        r_busy_cnt;
  logic [CHAIN_LEN-1:0] r_chain;
  logic [CHAIN_LEN-2:0] r_asm;
  logic [BW-1:0]        r_bit_cnt;
  logic [WW-1:0]        r_word_cnt;
  logic [CHAIN_LEN-1:0] r_dft_out;
  logic                 r_op_ack;
  logic                 r_op_commit;
  logic                 r_dft_ack;
  logic                 r_strobe;
  logic                 r_dft_commit;

  logic [CHAIN_LEN-1:0] w_new_acc;
  logic [CHAIN_LEN-1:0] w_word;
  logic [CHAIN_LEN-1:0] w_next_word;

`ifdef DUFT_RESP_SAT_EN
  logic                 r_sat;
  logic [CHAIN_LEN:0]   w_sum;
  assign w_sum     = {1'b0, r_acc} + {1'b0, r_operand};
  assign w_new_acc = w_sum[CHAIN_LEN] ? '1 : w_sum[CHAIN_LEN-1:0];
`else
  assign w_new_acc = r_acc + r_operand;
`endif

  // Completed word: the bits already assembled plus the bit leaving the chain this cycle.
  assign w_word = {r_asm, r_chain[CHAIN_LEN-1]};

  always_comb begin
    w_next_word = '0;
    if (r_word_cnt == '0) begin
      w_next_word = r_count;
    end
`ifdef DUFT_RESP_SAT_EN
    else if ((int'(r_word_cnt) + 1 == int'(DUMP_NBR) - 1) && (DUMP_NBR >= 3)) begin
      w_next_word = {{(CHAIN_LEN-1){1'b0}}, r_sat};
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= StIdle;
      r_operand    <= '0;
      r_acc        <= '0;
      r_count      <= '0;
      r_data_out   <= '0;
      r_busy_cnt   <= '0;
      r_chain      <= '0;
      r_asm        <= '0;
      r_bit_cnt    <= '0;
      r_word_cnt   <= '0;
      r_dft_out    <= '0;
      r_op_ack     <= 1'b0;
      r_op_commit  <= 1'b0;
      r_dft_ack    <= 1'b0;
      r_strobe     <= 1'b0;
      r_dft_commit <= 1'b0;
`ifdef DUFT_RESP_SAT_EN
      r_sat        <= 1'b0;
`endif
    end else begin
      r_op_ack  <= 1'b0;
      r_dft_ack <= 1'b0;
      r_strobe  <= 1'b0;
      case (r_state)
        StIdle: begin
          if (dut_val_op) begin
            r_operand <= data_in;
            r_op_ack  <= 1'b1;
            r_state   <= StAck;
          end else if (dft_val_op) begin
            r_dft_ack <= 1'b1;
            r_state   <= StDack;
          end
        end
        StAck: begin
          r_busy_cnt <= LatInit;
          r_state    <= StBusy;
        end
        StBusy: begin
          if (!ex_sen) begin
            if (r_busy_cnt == '0) begin
              r_acc       <= w_new_acc;
              r_data_out  <= w_new_acc;
              r_count     <= r_count + 1'b1;
              r_op_commit <= 1'b1;
              r_state     <= StCommit;
`ifdef DUFT_RESP_SAT_EN
              if (w_sum[CHAIN_LEN]) r_sat <= 1'b1;
`endif
            end else begin
              r_busy_cnt <= r_busy_cnt - 1'b1;
            end
          end
        end
        StCommit: begin
          if (dut_commit_ack) begin
            r_op_commit <= 1'b0;
            r_state     <= StIdle;
          end
        end
        // acc/count cannot change until the dump finishes, so they serve as the snapshot.
        StDack: begin
          r_chain    <= r_acc;
          r_bit_cnt  <= '0;
          r_word_cnt <= '0;
          r_state    <= StDshift;
        end
        StDshift: begin
          r_asm   <= w_word[CHAIN_LEN-2:0];
          r_chain <= r_chain << 1;
          if (r_bit_cnt == LastBit) begin
            r_dft_out <= w_word;
            r_strobe  <= 1'b1;
            r_bit_cnt <= '0;
            r_chain   <= w_next_word;
            if (r_word_cnt == LastWord) begin
              r_dft_commit <= 1'b1;
              r_state      <= StDcommit;
            end else begin
              r_word_cnt <= r_word_cnt + 1'b1;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        StDcommit: begin
          if (dft_commit_ack) begin
            r_dft_commit <= 1'b0;
            r_state      <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign data_out       = r_data_out;
  assign dut_op_ack     = r_op_ack;
  assign dut_op_commit  = r_op_commit;
  assign dft_op_ack     = r_dft_ack;
  assign dft_out        = r_dft_out;
  assign dft_out_strobe = r_strobe;
  assign dft_op_commit  = r_dft_commit;

endmodule

// File: tb/tb_dut_handshake_responder.sv
// Self-checking bench for dut_handshake_responder: directed and randomized ops/dumps vs a
// transaction-level model of accumulator, commit count and dump contents.
module tb_dut_handshake_responder;

  localparam int unsigned CL = 32;
  localparam int unsigned DN = 2;
  localparam int unsigned OL = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [CL-1:0] data_in;
  logic [CL-1:0] data_out;
  logic          dut_val_op, dut_op_ack, dut_op_commit, dut_commit_ack, ex_sen;
  logic          dft_val_op, dft_op_ack, dft_out_strobe, dft_op_commit, dft_commit_ack;
  logic [CL-1:0] dft_out;

  int checks = 0;
  int errors = 0;

  logic [CL-1:0] m_acc;
  logic [CL-1:0] m_cnt;
  logic          m_sat;

  dut_handshake_responder #(
    .CHAIN_LEN (CL),
    .DUMP_NBR  (DN),
    .OP_LATENCY(OL)
  ) u_dut (
    .clk           (clk),
    .reset         (reset),
    .data_in       (data_in),
    .data_out      (data_out),
    .dut_val_op    (dut_val_op),
    .dut_op_ack    (dut_op_ack),
    .dut_op_commit (dut_op_commit),
    .dut_commit_ack(dut_commit_ack),
    .ex_sen        (ex_sen),
    .dft_val_op    (dft_val_op),
    .dft_op_ack    (dft_op_ack),
    .dft_out       (dft_out),
    .dft_out_strobe(dft_out_strobe),
    .dft_op_commit (dft_op_commit),
    .dft_commit_ack(dft_commit_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [CL-1:0] got, input logic [CL-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_acc = '0;
    m_cnt = '0;
    m_sat = 1'b0;
  endtask

  task automatic model_add(input logic [CL-1:0] op);
    logic [CL:0] s;
    s = {1'b0, m_acc} + {1'b0, op};
`ifdef DUFT_RESP_SAT_EN
    if (s[CL]) begin
      m_acc = '1;
      m_sat = 1'b1;
    end else begin
      m_acc = s[CL-1:0];
    end
`else
    m_acc = s[CL-1:0];
`endif
    m_cnt = m_cnt + 1;
  endtask

  function automatic logic [CL-1:0] exp_word(input int w);
    if (w == 0) return m_acc;
    if (w == 1) return m_cnt;
`ifdef DUFT_RESP_SAT_EN
    if (w == int'(DN) - 1 && w >= 2) return {{(CL-1){1'b0}}, m_sat};
`endif
    return '0;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_data_out"}, data_out, '0);
    check({tag, "_op_ack"}, CL'(dut_op_ack), '0);
    check({tag, "_op_commit"}, CL'(dut_op_commit), '0);
    check({tag, "_dft_ack"}, CL'(dft_op_ack), '0);
    check({tag, "_dft_out"}, dft_out, '0);
    check({tag, "_strobe"}, CL'(dft_out_strobe), '0);
    check({tag, "_dft_commit"}, CL'(dft_op_commit), '0);
  endtask

  // One operation; stall = number of BUSY edges with ex_sen held high.
  task automatic do_op(input logic [CL-1:0] op, input int stall, input logic hold_dft,
                       input int ack_wait);
    int   k;
    logic got;
    logic dft_seen;
    data_in    = op;
    dut_val_op = 1'b1;
    dft_val_op = hold_dft;
    tick();
    check("op_ack_pulse", CL'(dut_op_ack), CL'(1));
    check("dft_ack_blocked", CL'(dft_op_ack), '0);
    dut_val_op = 1'b0;
    data_in    = $urandom;
    model_add(op);
    k        = 1;
    got      = 1'b0;
    dft_seen = 1'b0;
    while (k < 200 && !got) begin
      ex_sen         = (k >= 2 && k < 2 + stall);
      dut_commit_ack = 1'($urandom_range(0, 1));
      tick();
      if (k == 1) check("op_ack_end", CL'(dut_op_ack), '0);
      if (dft_op_ack) dft_seen = 1'b1;
      if (dut_op_commit) got = 1'b1;
      else k++;
    end
    ex_sen         = 1'b0;
    dut_commit_ack = 1'b0;
    check("op_latency", CL'(k), CL'(int'(OL) + 1 + stall));
    check("dft_ack_during_op", CL'(dft_seen), '0);
    check("data_out", data_out, m_acc);
    repeat (ack_wait) begin
      tick();
      check("commit_held", CL'(dut_op_commit), CL'(1));
      check("data_out_held", data_out, m_acc);
    end
    dut_commit_ack = 1'b1;
    tick();
    check("commit_release", CL'(dut_op_commit), '0);
    dut_commit_ack = 1'b0;
  endtask

  task automatic do_dump(input int ack_wait);
    int   k;
    int   w;
    logic op_seen;
    dft_val_op = 1'b1;
    tick();
    check("dft_ack_pulse", CL'(dft_op_ack), CL'(1));
    dft_val_op = 1'b0;
    k       = 1;
    w       = 0;
    op_seen = 1'b0;
    while (k < 2000 && w < int'(DN)) begin
      dut_val_op = 1'($urandom_range(0, 1));
      tick();
      if (k == 1) check("dft_ack_end", CL'(dft_op_ack), '0);
      if (dut_op_ack) op_seen = 1'b1;
      if (dft_out_strobe) begin
        check("dump_word", dft_out, exp_word(w));
        check("strobe_time", CL'(k), CL'((w + 1) * int'(CL) + 1));
        w++;
      end
      k++;
    end
    dut_val_op = 1'b0;
    check("dump_words", CL'(w), CL'(DN));
    check("op_ack_during_dump", CL'(op_seen), '0);
    check("dft_commit", CL'(dft_op_commit), CL'(1));
    repeat (ack_wait) begin
      tick();
      check("dft_commit_held", CL'(dft_op_commit), CL'(1));
      check("dft_out_held", dft_out, exp_word(int'(DN) - 1));
    end
    dft_commit_ack = 1'b1;
    tick();
    check("dft_commit_release", CL'(dft_op_commit), '0);
    dft_commit_ack = 1'b0;
  endtask

  initial begin
    int   k;
    logic seen;
    reset          = 1'b0;
    data_in        = '0;
    dut_val_op     = 1'b0;
    dut_commit_ack = 1'b0;
    ex_sen         = 1'b0;
    dft_val_op     = 1'b0;
    dft_commit_ack = 1'b0;
    model_reset();
    #12;
    check_all_zero("reset");
    reset = 1'b1;
    tick();

    do_op(CL'(5), 0, 1'b0, 3);
    do_op(CL'(2), 0, 1'b0, 0);
    do_dump(2);
    do_op(32'hFFFF_FFF8, 0, 1'b0, 1);
    do_op(CL'(2), 0, 1'b0, 0);
    do_op($urandom, 10, 1'b0, 0);
    // Both requests together: op wins, held dump request is served afterwards.
    do_op($urandom, 0, 1'b1, 0);
    do_dump(1);

    for (int i = 0; i < 6; i++) begin
      do_op($urandom, $urandom_range(0, 6), 1'b0, $urandom_range(0, 3));
      if (i % 2 == 1) do_dump($urandom_range(0, 2));
    end

    // Reset during the shift phase, after the first strobe.
    dft_val_op = 1'b1;
    tick();
    dft_val_op = 1'b0;
    k    = 0;
    seen = 1'b0;
    while (k < 200 && !seen) begin
      tick();
      seen = dft_out_strobe;
      k++;
    end
    check("reset_test_strobe", CL'(seen), CL'(1));
    repeat (5) tick();
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    tick();
    check_all_zero("reset_hold");
    reset = 1'b1;
    model_reset();
    repeat (2) begin
      tick();
      check("post_reset_strobe", CL'(dft_out_strobe), '0);
    end
    do_dump(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
